skid_reg: RTL and testbench

SKID_REG -- requirements
Module: skid_reg

---
 rtl/skid_pkg.sv | 13 +
 rtl/skid_reg_sat_counter.sv | 27 ++
 rtl/skid_reg.sv | 101 ++++++++++
 tb/tb_skid_reg.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared types and constants for the skid register.
package skid_pkg;

  // Occupancy of the two-entry skid register.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned SKID_CNT_W = 32;

endpackage

// File: rtl/skid_reg_sat_counter.sv
// Saturating up-counter: counts cycles with en_i high, sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Increment only while enabled and not already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared by reset only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/skid_reg.sv
// Two-entry skid register: breaks the ready path between upstream and
// downstream while sustaining one item per cycle.
// Optional: define SKID_REG_STALL_CNT_EN to add the 32-bit stall_cnt output
// counting cycles where upstream is held off (in_valid=1, in_ready=0).
module skid_reg
  import skid_pkg::*;
#(
  parameter int unsigned SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out_data,
  input  logic            flush
`ifdef SKID_REG_STALL_CNT_EN
  ,
  output logic [SKID_CNT_W-1:0] stall_cnt
`endif
);

  skid_state_t     state_q;
  logic [SIZE-1:0] main_q, skid_q;
  logic            in_rdy_q, out_vld_q;
  logic            in_fire, out_fire;

  assign in_fire  = in_valid  & in_rdy_q;
  assign out_fire = out_vld_q & out_ready;

  // Occupancy FSM; handshake outputs are registered alongside the state so
  // in_ready/out_valid come straight from flops. Flush only moves the state,
  // leaving payload registers untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else if (flush) begin
      state_q   <= EMPTY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q   <= BUSY;
            main_q    <= in_data;
            out_vld_q <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state_q  <= FULL;
            skid_q   <= in_data;
            in_rdy_q <= 1'b0;
          end else if (out_fire) begin
            state_q   <= EMPTY;
            out_vld_q <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_q  <= BUSY;
            main_q   <= skid_q;
            in_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= EMPTY;
          in_rdy_q  <= 1'b1;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_rdy_q;
  assign out_valid = out_vld_q;
  assign out_data  = main_q;

`ifdef SKID_REG_STALL_CNT_EN
  sat_counter #(
    .W (SKID_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (in_valid & ~in_rdy_q),
    .cnt_o (stall_cnt)
  );
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Bench for skid_reg: directed vector table, hand sequences for async reset
// and stall counting, then randomized traffic against a queue model.
module tb_skid_reg;

  localparam int unsigned SIZE = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [SIZE-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [SIZE-1:0] out_data;
  logic            flush = 1'b0;
`ifdef SKID_REG_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skid_reg #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush)
`ifdef SKID_REG_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic        e_ir;
    logic        e_chk;
    logic [31:0] e_od;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
  endtask

  // Drive right away, then sample 1 after the following posedge.
  task automatic apply_now(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    drive(iv, d, ordy, fl);
    @(posedge clk); #1;
  endtask

  task automatic apply(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    @(negedge clk);
    apply_now(iv, d, ordy, fl);
  endtask

  task automatic add(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                     input logic ov, input logic ir, input logic c, input logic [31:0] od);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ov = ov; v.e_ir = ir; v.e_chk = c; v.e_od = od;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Queue model: capacity two, order preserved, flush empties it.
  logic [31:0] mq[$];
  logic [31:0] m_stall;

  initial begin
    // single item
    add(1, 32'hA5A5A5A5, 1, 0, 1, 1, 1, 32'hA5A5A5A5);
    add(0, 32'h0,        1, 0, 0, 1, 0, 32'h0);
    // streaming 1..8
    for (int i = 1; i <= 8; i++) add(1, i, 1, 0, 1, 1, 1, i);
    add(0, 32'h0, 1, 0, 0, 1, 0, 32'h0);
    // backpressure
    add(1, 32'h11, 0, 0, 1, 1, 1, 32'h11);
    add(1, 32'h22, 0, 0, 1, 0, 1, 32'h11);
    add(1, 32'h33, 0, 0, 1, 0, 1, 32'h11);
    add(1, 32'h33, 1, 0, 1, 1, 1, 32'h22);
    add(1, 32'h33, 1, 0, 1, 1, 1, 32'h33);
    add(0, 32'h0,  1, 0, 0, 1, 0, 32'h0);
    // flush while FULL with 0x44 offered; payload register keeps 0x55
    add(1, 32'h55, 0, 0, 1, 1, 1, 32'h55);
    add(1, 32'h66, 0, 0, 1, 0, 1, 32'h55);
    add(1, 32'h44, 0, 1, 0, 1, 1, 32'h55);
    add(0, 32'h0,  1, 0, 0, 1, 1, 32'h55);
    // accepted again right after flush
    add(1, 32'h77, 1, 0, 1, 1, 1, 32'h77);
    add(0, 32'h0,  1, 0, 0, 1, 0, 32'h0);

    // reset state while rst_n is low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_data",  out_data,  0);
`ifdef SKID_REG_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif

    // release and use the very first posedge
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      if (i == 0) apply_now(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      else        apply(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].e_ov);
      chk($sformatf("vec%0d_in_ready", i),  in_ready,  tbl[i].e_ir);
      if (tbl[i].e_chk) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].e_od);
    end

    // async reset between edges while FULL
    apply(1, 32'h81, 0, 0);
    apply(1, 32'h82, 0, 0);
    chk("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready",  in_ready,  1);
    chk("async_out_data",  out_data,  0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_now(1, 32'h99, 0, 0);
    chk("post_rst_out_valid", out_valid, 1);
    chk("post_rst_out_data",  out_data,  32'h99);

`ifdef SKID_REG_STALL_CNT_EN
    // now BUSY with 0x99: one more fills it, then 5 stalled cycles
    apply(1, 32'h9A, 0, 0);
    chk("stall_fill", stall_cnt, 0);
    for (int i = 0; i < 5; i++) apply(1, 32'h9B, 0, 0);
    chk("stall_five", stall_cnt, 5);
    apply(0, 32'h0, 0, 1);
    chk("stall_after_flush", stall_cnt, 5);
    chk("flush_in_ready", in_ready, 1);
`endif

    // randomized traffic against the queue model
    do_reset();
    mq.delete();
    m_stall = 0;
    for (int c = 0; c < 3000; c++) begin
      logic iv, ordy, fl, can_in, has_out;
      logic [31:0] d;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 31) == 0);
      d    = $urandom;
      can_in  = (mq.size() < 2);
      has_out = (mq.size() > 0);
      @(negedge clk);
      apply_now(iv, d, ordy, fl);
      if (iv && !can_in && m_stall != 32'hFFFFFFFF) m_stall++;
      if (fl) mq.delete();
      else begin
        if (has_out && ordy) void'(mq.pop_front());
        if (iv && can_in) mq.push_back(d);
      end
      chk("rnd_out_valid", out_valid, mq.size() > 0);
      chk("rnd_in_ready",  in_ready,  mq.size() < 2);
      if (mq.size() > 0) chk("rnd_out_data", out_data, mq[0]);
`ifdef SKID_REG_STALL_CNT_EN
      chk("rnd_stall_cnt", stall_cnt, m_stall);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
